// File: rtl/vga_block_cfg_seq.sv
// Programs up to four vga_block registers over an AXI4-Lite master port.
// Masked registers are written one at a time in ascending index order.
module vga_block_cfg_seq #(
    parameter int C_M_AXI_ADDR_WIDTH = 4,
    parameter int C_BASE_ADDR        = 0
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic                          cfg_req,
    input  logic [127:0]                  cfg_data,
    input  logic [3:0]                    cfg_mask,
    output logic                          cfg_busy,
    output logic                          cfg_done,
    output logic                          cfg_err,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic [2:0]                    M_AXI_AWPROT,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [31:0]                   M_AXI_WDATA,
    output logic [3:0]                    M_AXI_WSTRB,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                        state_q,   state_d;
    logic [127:0]                  data_q,    data_d;
    logic [3:0]                    mask_q,    mask_d;
    logic [1:0]                    idx_q,     idx_d;
    logic                          awvalid_q, awvalid_d;
    logic                          wvalid_q,  wvalid_d;
    logic                          aw_ok_q,   aw_ok_d;
    logic                          w_ok_q,    w_ok_d;
    logic                          bready_q,  bready_d;
    logic                          busy_q,    busy_d;
    logic                          done_q,    done_d;
    logic                          err_q,     err_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0] awaddr_q,  awaddr_d;
    logic [31:0]                   wdata_q,   wdata_d;

    logic       aw_hs, w_hs, b_hs;
    logic [3:0] remaining;
    logic [1:0] first_idx, next_idx;

    function automatic logic [1:0] lowest_idx(input logic [3:0] m);
        logic [1:0] k;
        if (m[0])      k = 2'd0;
        else if (m[1]) k = 2'd1;
        else if (m[2]) k = 2'd2;
        else           k = 2'd3;
        return k;
    endfunction

    function automatic logic [C_M_AXI_ADDR_WIDTH-1:0] reg_addr(input logic [1:0] k);
        return C_M_AXI_ADDR_WIDTH'(C_BASE_ADDR + 4 * int'(k));
    endfunction

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        mask_d    = mask_q;
        idx_d     = idx_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        aw_ok_d   = aw_ok_q;
        w_ok_d    = w_ok_q;
        bready_d  = bready_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;

        aw_hs     = awvalid_q & M_AXI_AWREADY;
        w_hs      = wvalid_q & M_AXI_WREADY;
        b_hs      = bready_q & M_AXI_BVALID;
        remaining = mask_q & ~(4'b0001 << idx_q);
        first_idx = lowest_idx(cfg_mask);
        next_idx  = lowest_idx(remaining);

        case (state_q)
            IDLE: begin
                if (cfg_req) begin
                    data_d  = cfg_data;
                    mask_d  = cfg_mask;
                    err_d   = 1'b0;
                    aw_ok_d = 1'b0;
                    w_ok_d  = 1'b0;
                    if (cfg_mask != 4'b0000) begin
                        state_d   = ADDR;
                        busy_d    = 1'b1;
                        idx_d     = first_idx;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = reg_addr(first_idx);
                        wdata_d   = cfg_data[{first_idx, 5'd0} +: 32];
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            // AW and W complete independently; the response phase waits for both.
            ADDR: begin
                aw_ok_d   = aw_ok_q | aw_hs;
                w_ok_d    = w_ok_q | w_hs;
                awvalid_d = awvalid_q & ~aw_hs;
                wvalid_d  = wvalid_q & ~w_hs;
                if (aw_ok_d && w_ok_d) begin
                    state_d  = RESP;
                    bready_d = 1'b1;
                end
            end
            RESP: begin
                if (b_hs) begin
                    bready_d = 1'b0;
                    mask_d   = remaining;
                    aw_ok_d  = 1'b0;
                    w_ok_d   = 1'b0;
                    if (M_AXI_BRESP != 2'b00) begin
                        err_d = 1'b1;
                    end
                    if (remaining != 4'b0000) begin
                        state_d   = ADDR;
                        idx_d     = next_idx;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = reg_addr(next_idx);
                        wdata_d   = data_q[{next_idx, 5'd0} +: 32];
                    end else begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= IDLE;
            data_q    <= '0;
            mask_q    <= '0;
            idx_q     <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            aw_ok_q   <= 1'b0;
            w_ok_q    <= 1'b0;
            bready_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            mask_q    <= mask_d;
            idx_q     <= idx_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            aw_ok_q   <= aw_ok_d;
            w_ok_q    <= w_ok_d;
            bready_q  <= bready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign cfg_busy      = busy_q;
    assign cfg_done      = done_q;
    assign cfg_err       = err_q;
    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = 4'hF;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;

endmodule

// File: tb/tb_vga_block_cfg_seq.sv
// Directed bench for vga_block_cfg_seq: AXI4-Lite slave model with a write
// scoreboard, configurable ready latencies and BRESP error injection.
module tb_vga_block_cfg_seq;

    logic         ACLK;
    logic         ARESETN;
    logic         cfg_req;
    logic [127:0] cfg_data;
    logic [3:0]   cfg_mask;
    logic         cfg_busy;
    logic         cfg_done;
    logic         cfg_err;
    logic [3:0]   M_AXI_AWADDR;
    logic [2:0]   M_AXI_AWPROT;
    logic         M_AXI_AWVALID;
    logic         M_AXI_AWREADY;
    logic [31:0]  M_AXI_WDATA;
    logic [3:0]   M_AXI_WSTRB;
    logic         M_AXI_WVALID;
    logic         M_AXI_WREADY;
    logic [1:0]   M_AXI_BRESP;
    logic         M_AXI_BVALID;
    logic         M_AXI_BREADY;

    vga_block_cfg_seq #(
        .C_M_AXI_ADDR_WIDTH(4),
        .C_BASE_ADDR       (0)
    ) dut (
        .ACLK         (ACLK),
        .ARESETN      (ARESETN),
        .cfg_req      (cfg_req),
        .cfg_data     (cfg_data),
        .cfg_mask     (cfg_mask),
        .cfg_busy     (cfg_busy),
        .cfg_done     (cfg_done),
        .cfg_err      (cfg_err),
        .M_AXI_AWADDR (M_AXI_AWADDR),
        .M_AXI_AWPROT (M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID),
        .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA  (M_AXI_WDATA),
        .M_AXI_WSTRB  (M_AXI_WSTRB),
        .M_AXI_WVALID (M_AXI_WVALID),
        .M_AXI_WREADY (M_AXI_WREADY),
        .M_AXI_BRESP  (M_AXI_BRESP),
        .M_AXI_BVALID (M_AXI_BVALID),
        .M_AXI_BREADY (M_AXI_BREADY)
    );

    typedef struct packed {
        logic [3:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          write_count = 0;
    int          aw_lat      = 0;
    int          w_lat       = 0;
    logic        err_en      = 1'b0;
    logic [3:0]  err_addr    = 4'h0;
    logic [31:0] mem [4];

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Slave model: decides handshakes from values seen on the previous falling edge.
    initial begin
        logic        prev_awv, prev_wv, prev_bready;
        logic [3:0]  prev_awaddr, got_addr;
        logic [31:0] prev_wdata, got_data;
        logic        aw_got, w_got, aw_hs, w_hs;
        int          cnt;
        exp_t        e;
        M_AXI_AWREADY = 1'b0;
        M_AXI_WREADY  = 1'b0;
        M_AXI_BVALID  = 1'b0;
        M_AXI_BRESP   = 2'b00;
        prev_awv = 1'b0; prev_wv = 1'b0; prev_bready = 1'b0;
        prev_awaddr = '0; prev_wdata = '0; got_addr = '0; got_data = '0;
        aw_got = 1'b0; w_got = 1'b0; cnt = 0;
        forever begin
            @(negedge ACLK);
            if (!ARESETN) begin
                M_AXI_AWREADY = 1'b0;
                M_AXI_WREADY  = 1'b0;
                M_AXI_BVALID  = 1'b0;
                M_AXI_BRESP   = 2'b00;
                prev_awv = 1'b0; prev_wv = 1'b0; prev_bready = 1'b0;
                aw_got = 1'b0; w_got = 1'b0; cnt = 0;
            end else begin
                aw_hs = prev_awv && M_AXI_AWREADY;
                w_hs  = prev_wv && M_AXI_WREADY;
                if (prev_awv && !aw_hs)
                    check("aw_hold", {27'b0, M_AXI_AWVALID, M_AXI_AWADDR}, {27'b0, 1'b1, prev_awaddr});
                if (prev_wv && !w_hs) begin
                    check("wvalid_hold", {31'b0, M_AXI_WVALID}, 32'd1);
                    check("wdata_hold", M_AXI_WDATA, prev_wdata);
                end
                if (aw_hs) begin
                    aw_got   = 1'b1;
                    got_addr = prev_awaddr;
                end
                if (w_hs) begin
                    w_got    = 1'b1;
                    got_data = prev_wdata;
                end
                if (M_AXI_BVALID && prev_bready) M_AXI_BVALID = 1'b0;
                if (aw_got && !w_got) check("awvalid_drop", {31'b0, M_AXI_AWVALID}, 32'd0);
                if (w_got && !aw_got) check("wvalid_drop", {31'b0, M_AXI_WVALID}, 32'd0);
                if ((aw_got ^ w_got) || M_AXI_AWVALID || M_AXI_WVALID)
                    check("bready_early", {31'b0, M_AXI_BREADY}, 32'd0);
                if (aw_got && w_got) begin
                    check("write_expected", {31'b0, exp_q.size() != 0}, 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("awaddr", {28'b0, got_addr}, {28'b0, e.addr});
                        check("wdata", got_data, e.data);
                    end
                    mem[got_addr[3:2]] = got_data;
                    write_count++;
                    M_AXI_BVALID = 1'b1;
                    M_AXI_BRESP  = (err_en && got_addr == err_addr) ? 2'b10 : 2'b00;
                    aw_got = 1'b0;
                    w_got  = 1'b0;
                    cnt    = 0;
                end
                M_AXI_AWREADY = M_AXI_AWVALID && (cnt >= aw_lat);
                M_AXI_WREADY  = M_AXI_WVALID && (cnt >= w_lat);
                if (M_AXI_AWVALID || M_AXI_WVALID) cnt++;
                prev_awv    = M_AXI_AWVALID;
                prev_awaddr = M_AXI_AWADDR;
                prev_wv     = M_AXI_WVALID;
                prev_wdata  = M_AXI_WDATA;
                prev_bready = M_AXI_BREADY;
            end
        end
    end

    // Called on a falling edge; the request is accepted on the next rising edge.
    task automatic applyStimulus(input logic [127:0] data, input logic [3:0] mask);
        for (int k = 0; k < 4; k++) begin
            if (mask[k]) exp_q.push_back({4'(4 * k), data[32 * k +: 32]});
        end
        cfg_req  = 1'b1;
        cfg_data = data;
        cfg_mask = mask;
        @(negedge ACLK);
        cfg_req  = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic exp_err, input int exp_lat);
        int lat = 0;
        while (!cfg_done && lat < 200) begin
            @(negedge ACLK);
            lat++;
        end
        check({tag, "/done"}, {31'b0, cfg_done}, 32'd1);
        if (exp_lat >= 0) check({tag, "/latency"}, lat, exp_lat);
        check({tag, "/busy_at_done"}, {31'b0, cfg_busy}, 32'd0);
        check({tag, "/err_at_done"}, {31'b0, cfg_err}, {31'b0, exp_err});
        check({tag, "/sb_empty"}, exp_q.size(), 32'd0);
        @(negedge ACLK);
        check({tag, "/done_pulse"}, {31'b0, cfg_done}, 32'd0);
        check({tag, "/err_held"}, {31'b0, cfg_err}, {31'b0, exp_err});
    endtask

    initial begin
        int wc;
        ARESETN  = 1'b1;
        cfg_req  = 1'b0;
        cfg_data = '0;
        cfg_mask = '0;
        for (int k = 0; k < 4; k++) mem[k] = '0;
        #1 ARESETN = 1'b0;
        repeat (2) @(negedge ACLK);
        check("rst/busy", {31'b0, cfg_busy}, 32'd0);
        check("rst/done", {31'b0, cfg_done}, 32'd0);
        check("rst/err", {31'b0, cfg_err}, 32'd0);
        check("rst/valids", {29'b0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}, 32'd0);
        check("rst/awaddr", {28'b0, M_AXI_AWADDR}, 32'd0);
        check("rst/wdata", M_AXI_WDATA, 32'd0);
        check("rst/awprot", {29'b0, M_AXI_AWPROT}, 32'd0);
        check("rst/wstrb", {28'b0, M_AXI_WSTRB}, 32'hF);
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);

        $display("[TB] all four registers, zero-wait slave");
        applyStimulus({32'd4, 32'd3, 32'd2, 32'd1}, 4'hF);
        check("maskF/busy", {31'b0, cfg_busy}, 32'd1);
        check("maskF/valid_pair", {30'b0, M_AXI_AWVALID, M_AXI_WVALID}, 32'd3);
        checkOutput("maskF", 1'b0, 8);
        for (int k = 0; k < 4; k++) check($sformatf("readback%0d", k), mem[k], 32'(k + 1));

        $display("[TB] sparse mask 1010");
        applyStimulus({32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000}, 4'b1010);
        checkOutput("mask1010", 1'b0, 4);

        $display("[TB] empty mask");
        wc = write_count;
        applyStimulus({4{32'hFFFF_FFFF}}, 4'b0000);
        check("mask0/done_next", {31'b0, cfg_done}, 32'd1);
        check("mask0/no_awvalid", {31'b0, M_AXI_AWVALID}, 32'd0);
        checkOutput("mask0", 1'b0, 0);
        check("mask0/no_writes", write_count - wc, 32'd0);

        $display("[TB] single register minimum latency");
        applyStimulus({32'h0, 32'h1234_5678, 32'h0, 32'h0}, 4'b0100);
        checkOutput("mask4", 1'b0, 2);

        $display("[TB] WREADY three cycles after AWREADY");
        w_lat = 3;
        applyStimulus({32'h0, 32'h0, 32'h5A5A_A5A5, 32'h0}, 4'b0010);
        checkOutput("wdelay", 1'b0, 5);
        check("wdelay/readback", mem[1], 32'h5A5A_A5A5);
        w_lat = 0;

        $display("[TB] SLVERR on register 1");
        err_en   = 1'b1;
        err_addr = 4'h4;
        wc = write_count;
        applyStimulus({32'h40, 32'h30, 32'h20, 32'h10}, 4'hF);
        checkOutput("slverr", 1'b1, 8);
        check("slverr/writes", write_count - wc, 32'd4);
        repeat (3) @(negedge ACLK);
        check("slverr/err_sticky", {31'b0, cfg_err}, 32'd1);
        err_en = 1'b0;
        applyStimulus({32'h0, 32'h0, 32'h0, 32'h0000_0077}, 4'b0001);
        check("slverr/err_cleared", {31'b0, cfg_err}, 32'd0);
        checkOutput("after_err", 1'b0, 2);

        $display("[TB] cfg_req held high through a sequence");
        wc = write_count;
        exp_q.push_back({4'h0, 32'h0000_0099});
        cfg_req  = 1'b1;
        cfg_data = {96'h0, 32'h0000_0099};
        cfg_mask = 4'b0001;
        checkOutput("held", 1'b0, 3);
        cfg_req = 1'b0;
        repeat (3) @(negedge ACLK);
        check("held/no_second", {31'b0, cfg_busy}, 32'd0);
        check("held/one_write", write_count - wc, 32'd1);

        $display("[TB] reset asserted mid-transaction");
        aw_lat = 6;
        w_lat  = 6;
        applyStimulus({32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF}, 4'b0001);
        @(negedge ACLK);
        check("midrst/in_addr", {30'b0, M_AXI_AWVALID, M_AXI_WVALID}, 32'd3);
        #2 ARESETN = 1'b0;
        #1;
        check("midrst/valids", {29'b0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}, 32'd0);
        check("midrst/busy", {31'b0, cfg_busy}, 32'd0);
        check("midrst/awaddr_wdata", {28'b0, M_AXI_AWADDR} | M_AXI_WDATA, 32'd0);
        check("midrst/wstrb", {28'b0, M_AXI_WSTRB}, 32'hF);
        repeat (2) @(negedge ACLK);
        exp_q.delete();
        aw_lat  = 0;
        w_lat   = 0;
        ARESETN = 1'b1;
        applyStimulus({32'hCAFE_0003, 32'h0, 32'h0, 32'hCAFE_0000}, 4'b1001);
        checkOutput("postrst", 1'b0, 4);
        check("postrst/readback3", mem[3], 32'hCAFE_0003);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
